// File: rtl/fifo_mem.sv
// fifo_mem: DSIZE x 2**ASIZE register array.
// Synchronous write, asynchronous read; contents are never reset.
module fifo_mem #(
   parameter int DSIZE = 8,
   parameter int ASIZE = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [ASIZE-1:0] waddr,
   input  logic [DSIZE-1:0] wdata,
   input  logic [ASIZE-1:0] raddr,
   output logic [DSIZE-1:0] rdata
);

   localparam int DEPTH = 2**ASIZE;

   logic [DSIZE-1:0] mem [DEPTH];

   // store the write word at the write address on an accepted write
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock FIFO with optional first-word-fall-through,
// occupancy count, almost-full/empty thresholds and sticky error flags.
module sync_fifo_fwft #(
   parameter int DSIZE    = 8,
   parameter int ASIZE    = 4,
   parameter int FWFT     = 0,
   parameter int AF_LEVEL = 2**ASIZE-2,
   parameter int AE_LEVEL = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             winc,
   input  logic [DSIZE-1:0] wdata,
   output logic             wfull,
   output logic             walmost_full,
   input  logic             rinc,
   output logic [DSIZE-1:0] rdata,
   output logic             rempty,
   output logic             ralmost_empty,
   output logic [ASIZE:0]   count,
   output logic             overflow,
   output logic             underflow,
   input  logic             clr_err
);

   localparam int DEPTH = 2**ASIZE;
   localparam logic [ASIZE:0] FULL_CNT = (ASIZE+1)'(DEPTH);
   localparam logic [ASIZE:0] AF_CNT   = (ASIZE+1)'(AF_LEVEL);
   localparam logic [ASIZE:0] AE_CNT   = (ASIZE+1)'(AE_LEVEL);

   if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("sync_fifo_fwft: AF_LEVEL out of range 1..DEPTH");
   end
   if (AE_LEVEL < 0 || AE_LEVEL > DEPTH-1) begin : g_bad_ae
      $error("sync_fifo_fwft: AE_LEVEL out of range 0..DEPTH-1");
   end

   logic [ASIZE:0]   wptr;
   logic [ASIZE:0]   rptr;
   logic             we;
   logic             re;
   logic [DSIZE-1:0] mem_rdata;

   assign count         = wptr - rptr;
   assign wfull         = (count == FULL_CNT);
   assign rempty        = (count == '0);
   assign walmost_full  = (count >= AF_CNT);
   assign ralmost_empty = (count <= AE_CNT);

   // full blocks writes even when a read is accepted in the same cycle
   assign we = winc && !wfull;
   assign re = rinc && !rempty;

   // binary pointers, one extra bit so full and empty differ
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (we) wptr <= wptr + 1'b1;
         if (re) rptr <= rptr + 1'b1;
      end
   end

   // sticky error flags; a new error event wins over clr_err
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (winc && wfull)      overflow <= 1'b1;
         else if (clr_err)       overflow <= 1'b0;
         if (rinc && rempty)     underflow <= 1'b1;
         else if (clr_err)       underflow <= 1'b0;
      end
   end

   fifo_mem #(
      .DSIZE(DSIZE),
      .ASIZE(ASIZE)
   ) u_mem (
      .clk  (clk),
      .we   (we),
      .waddr(wptr[ASIZE-1:0]),
      .wdata(wdata),
      .raddr(rptr[ASIZE-1:0]),
      .rdata(mem_rdata)
   );

   if (FWFT != 0) begin : g_fwft
      assign rdata = mem_rdata;
   end else begin : g_std
      logic [DSIZE-1:0] rdata_q;

      // load head word on an accepted read, hold otherwise
      always_ff @(posedge clk or posedge rst) begin
         if (rst)     rdata_q <= '0;
         else if (re) rdata_q <= mem_rdata;
      end

      assign rdata = rdata_q;
   end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft: directed checks of standard, FWFT and
// custom-threshold instances of sync_fifo_fwft.
module tb_sync_fifo_fwft;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   // instance a: standard read, default thresholds (AF=14, AE=2)
   logic       a_winc = 0, a_rinc = 0, a_clr = 0;
   logic [7:0] a_wdata = 0, a_rdata;
   logic       a_wfull, a_af, a_rempty, a_ae, a_ovf, a_unf;
   logic [4:0] a_count;

   // instance b: first-word-fall-through
   logic       b_winc = 0, b_rinc = 0, b_clr = 0;
   logic [7:0] b_wdata = 0, b_rdata;
   logic       b_wfull, b_af, b_rempty, b_ae, b_ovf, b_unf;
   logic [4:0] b_count;

   // instance c: AF_LEVEL=12, AE_LEVEL=2
   logic       c_winc = 0, c_rinc = 0, c_clr = 0;
   logic [7:0] c_wdata = 0, c_rdata;
   logic       c_wfull, c_af, c_rempty, c_ae, c_ovf, c_unf;
   logic [4:0] c_count;

   int n_tests = 0;
   int n_fail  = 0;

   sync_fifo_fwft #(.DSIZE(8), .ASIZE(4), .FWFT(0)) u_a (
      .clk(clk), .rst(rst), .winc(a_winc), .wdata(a_wdata),
      .wfull(a_wfull), .walmost_full(a_af), .rinc(a_rinc),
      .rdata(a_rdata), .rempty(a_rempty), .ralmost_empty(a_ae),
      .count(a_count), .overflow(a_ovf), .underflow(a_unf),
      .clr_err(a_clr)
   );

   sync_fifo_fwft #(.DSIZE(8), .ASIZE(4), .FWFT(1)) u_b (
      .clk(clk), .rst(rst), .winc(b_winc), .wdata(b_wdata),
      .wfull(b_wfull), .walmost_full(b_af), .rinc(b_rinc),
      .rdata(b_rdata), .rempty(b_rempty), .ralmost_empty(b_ae),
      .count(b_count), .overflow(b_ovf), .underflow(b_unf),
      .clr_err(b_clr)
   );

   sync_fifo_fwft #(.DSIZE(8), .ASIZE(4), .FWFT(0),
                    .AF_LEVEL(12), .AE_LEVEL(2)) u_c (
      .clk(clk), .rst(rst), .winc(c_winc), .wdata(c_wdata),
      .wfull(c_wfull), .walmost_full(c_af), .rinc(c_rinc),
      .rdata(c_rdata), .rempty(c_rempty), .ralmost_empty(c_ae),
      .count(c_count), .overflow(c_ovf), .underflow(c_unf),
      .clr_err(c_clr)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance one clock, settle just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // power-on reset
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // put some data in, then reset mid-cycle
      a_winc = 1;
      for (int i = 0; i < 3; i++) begin
         a_wdata = 8'(8'h50 + i);
         tick();
      end
      a_winc = 0;
      chk("pre_rst_count", 32'(a_count), 32'd3);
      #2 rst = 1'b1;
      #1;
      chk("rst_rempty", 32'(a_rempty), 32'd1);
      chk("rst_wfull",  32'(a_wfull),  32'd0);
      chk("rst_count",  32'(a_count),  32'd0);
      chk("rst_ae",     32'(a_ae),     32'd1);
      chk("rst_af",     32'(a_af),     32'd0);
      chk("rst_ovf",    32'(a_ovf),    32'd0);
      chk("rst_unf",    32'(a_unf),    32'd0);
      chk("rst_rdata",  32'(a_rdata),  32'd0);
      #2 rst = 1'b0;
      a_rinc = 1;
      tick();
      a_rinc = 0;
      chk("unf_after_rst",   32'(a_unf),   32'd1);
      chk("count_after_unf", 32'(a_count), 32'd0);
      a_clr = 1;
      tick();
      a_clr = 0;
      chk("unf_cleared", 32'(a_unf), 32'd0);

      // fill 0x10..0x1F
      a_winc = 1;
      for (int i = 0; i < 16; i++) begin
         a_wdata = 8'(8'h10 + i);
         tick();
         chk("fill_count", 32'(a_count), 32'(i + 1));
         chk("fill_af",    32'(a_af),    32'((i + 1) >= 14));
         chk("fill_full",  32'(a_wfull), 32'((i + 1) == 16));
      end
      a_wdata = 8'hEE;
      tick();
      a_winc = 0;
      chk("ovf_set",    32'(a_ovf),   32'd1);
      chk("ovf_count",  32'(a_count), 32'd16);

      // drain; rdata valid just after each rinc edge
      a_rinc = 1;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("drain_data", 32'(a_rdata), 32'(8'h10 + i));
      end
      chk("drain_empty", 32'(a_rempty), 32'd1);
      tick();
      a_rinc = 0;
      chk("rej_read_hold", 32'(a_rdata), 32'h1F);
      chk("rej_read_unf",  32'(a_unf),   32'd1);
      a_clr = 1;
      tick();
      a_clr = 0;
      chk("clr_ovf", 32'(a_ovf), 32'd0);
      chk("clr_unf", 32'(a_unf), 32'd0);

      // wrap-around
      a_winc = 1;
      for (int i = 0; i < 10; i++) begin
         a_wdata = 8'(8'h40 + i);
         tick();
      end
      a_winc = 0;
      a_rinc = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("wrap1_data", 32'(a_rdata), 32'(8'h40 + i));
      end
      a_rinc = 0;
      a_winc = 1;
      for (int i = 0; i < 16; i++) begin
         a_wdata = 8'(8'h80 + 3 * i);
         tick();
      end
      a_winc = 0;
      chk("wrap_peak", 32'(a_count), 32'd16);
      a_rinc = 1;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("wrap2_data", 32'(a_rdata), 32'(8'h80 + 3 * i));
      end
      a_rinc = 0;
      chk("wrap_empty", 32'(a_rempty), 32'd1);

      // simultaneous read/write at count 5
      a_winc = 1;
      for (int i = 0; i < 5; i++) begin
         a_wdata = 8'(8'hC0 + i);
         tick();
      end
      a_rinc = 1;
      for (int i = 0; i < 8; i++) begin
         a_wdata = 8'(8'hC5 + i);
         tick();
         chk("rw_count", 32'(a_count), 32'd5);
         chk("rw_data",  32'(a_rdata), 32'(8'hC0 + i));
      end
      a_winc = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rw_tail", 32'(a_rdata), 32'(8'hC8 + i));
      end
      chk("rw_empty", 32'(a_rempty), 32'd1);

      // simultaneous read/write while empty
      a_winc  = 1;
      a_wdata = 8'h77;
      tick();
      a_winc = 0;
      chk("rw0_count",  32'(a_count),  32'd1);
      chk("rw0_unf",    32'(a_unf),    32'd1);
      chk("rw0_rempty", 32'(a_rempty), 32'd0);
      tick();
      a_rinc = 0;
      chk("rw0_data", 32'(a_rdata), 32'h77);

      // FWFT
      b_winc  = 1;
      b_wdata = 8'hA5;
      tick();
      chk("fwft_rempty", 32'(b_rempty), 32'd0);
      chk("fwft_first",  32'(b_rdata),  32'hA5);
      b_wdata = 8'h3C;
      tick();
      b_winc = 0;
      chk("fwft_hold",   32'(b_rdata),  32'hA5);
      chk("fwft_count2", 32'(b_count),  32'd2);
      b_rinc = 1;
      tick();
      b_rinc = 0;
      chk("fwft_next",   32'(b_rdata),  32'h3C);
      chk("fwft_count1", 32'(b_count),  32'd1);

      // thresholds AF=12 AE=2
      chk("thr_ae0", 32'(c_ae), 32'd1);
      c_winc = 1;
      for (int i = 1; i <= 16; i++) begin
         c_wdata = 8'(i);
         tick();
         if (i <= 12) begin
            chk("thr_ae", 32'(c_ae), 32'(i <= 2));
            chk("thr_af", 32'(c_af), 32'(i >= 12));
         end
      end
      chk("thr_full", 32'(c_wfull), 32'd1);
      tick();
      c_winc = 0;
      chk("thr_ovf", 32'(c_ovf), 32'd1);
      c_clr = 1;
      tick();
      chk("thr_clr", 32'(c_ovf), 32'd0);
      c_winc = 1;
      tick();
      c_winc = 0;
      c_clr  = 0;
      chk("thr_set_wins", 32'(c_ovf), 32'd1);
      chk("thr_cnt_kept", 32'(c_count), 32'd16);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
